// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register with a 2-entry skid buffer, synchronous flush
// and NUM_WR register-file write lanes; mem_ready_o comes straight from a state flop.
module mem_wb_stage #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int NUM_WR    = 1,
    parameter bit ZERO_SUPP = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     mem_valid_i,
    output logic                     mem_ready_o,
    input  logic [NUM_WR*ADDR_W-1:0] mem_waddr_i,
    input  logic [NUM_WR*DATA_W-1:0] mem_wdata_i,
    input  logic [NUM_WR-1:0]        mem_we_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [NUM_WR*ADDR_W-1:0] wb_waddr_o,
    output logic [NUM_WR*DATA_W-1:0] wb_wdata_o,
    output logic [NUM_WR-1:0]        wb_we_o,
    output logic [1:0]               occupancy_o
);
    // Encoding equals the held-beat count, so occupancy and ready are plain flop bits
    typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b10} state_t;
    state_t state, state_n;
    logic [NUM_WR*ADDR_W-1:0] main_waddr, skid_waddr;
    logic [NUM_WR*DATA_W-1:0] main_wdata, skid_wdata;
    logic [NUM_WR-1:0]        main_we, skid_we, in_we;
    logic                     accept, retire, load_main, load_skid;

    assign occupancy_o = state;
    assign mem_ready_o = ~state[1];
    assign wb_valid_o  = |state;
    assign accept      = mem_valid_i & mem_ready_o;
    assign retire      = wb_valid_o & wb_ready_i;

    for (genvar k = 0; k < NUM_WR; k++) begin : g_lane
        assign in_we[k] = mem_we_i[k] & ~(ZERO_SUPP && mem_waddr_i[k*ADDR_W +: ADDR_W] == '0);
    end

    always_comb begin
        state_n   = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        if (flush_i)
            state_n = EMPTY;
        else
            unique case (state)
                EMPTY: begin
                    load_main = accept;
                    state_n   = accept ? ONE : EMPTY;
                end
                ONE: begin
                    load_main = accept & retire;
                    load_skid = accept & ~retire;
                    state_n   = load_skid ? FULL : (!accept && retire) ? EMPTY : ONE;
                end
                FULL: begin
                    load_main = retire;
                    state_n   = retire ? ONE : FULL;
                end
                default: state_n = EMPTY;
            endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            main_waddr <= '0;
            main_wdata <= '0;
            main_we    <= '0;
            skid_waddr <= '0;
            skid_wdata <= '0;
            skid_we    <= '0;
        end else begin
            state <= state_n;
            if (load_main) begin
                main_waddr <= (state == FULL) ? skid_waddr : mem_waddr_i;
                main_wdata <= (state == FULL) ? skid_wdata : mem_wdata_i;
                main_we    <= (state == FULL) ? skid_we : in_we;
            end
            if (load_skid) begin
                skid_waddr <= mem_waddr_i;
                skid_wdata <= mem_wdata_i;
                skid_we    <= in_we;
            end
        end
    end

    assign wb_waddr_o = main_waddr & {(NUM_WR*ADDR_W){wb_valid_o}};
    assign wb_wdata_o = main_wdata & {(NUM_WR*DATA_W){wb_valid_o}};
    assign wb_we_o    = main_we & {NUM_WR{wb_valid_o}};
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: random + directed scoreboard bench; u0 is 2-lane with r0 suppression,
// u1 is 1-lane without suppression, both fed the same handshake and lane-0 stimulus.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, mem_valid = 1'b0, wb_ready = 1'b0;
    logic [9:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic [1:0]  we = '0;
    logic        rdy0, vld0, rdy1, vld1;
    logic [9:0]  wa0;
    logic [63:0] wd0;
    logic [1:0]  we0, occ0, occ1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [0:0]  we1;
    int          checks = 0, errors = 0;

    typedef struct packed {
        logic [9:0]  a;
        logic [63:0] d;
        logic [1:0]  w;
    } beat_t;
    beat_t q[$];

    always #5 clk = ~clk;

    mem_wb_stage #(.ADDR_W(5), .DATA_W(32), .NUM_WR(2), .ZERO_SUPP(1'b1)) u0 (
        .clk(clk), .rst(rst), .flush_i(flush), .mem_valid_i(mem_valid), .mem_ready_o(rdy0),
        .mem_waddr_i(waddr), .mem_wdata_i(wdata), .mem_we_i(we), .wb_valid_o(vld0),
        .wb_ready_i(wb_ready), .wb_waddr_o(wa0), .wb_wdata_o(wd0), .wb_we_o(we0),
        .occupancy_o(occ0));

    mem_wb_stage #(.ADDR_W(5), .DATA_W(32), .NUM_WR(1), .ZERO_SUPP(1'b0)) u1 (
        .clk(clk), .rst(rst), .flush_i(flush), .mem_valid_i(mem_valid), .mem_ready_o(rdy1),
        .mem_waddr_i(waddr[4:0]), .mem_wdata_i(wdata[31:0]), .mem_we_i(we[0:0]),
        .wb_valid_o(vld1), .wb_ready_i(wb_ready), .wb_waddr_o(wa1), .wb_wdata_o(wd1),
        .wb_we_o(we1), .occupancy_o(occ1));

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most two beats; flush or reset empties it
    always @(posedge clk or negedge rst) begin
        if (!rst || flush)
            q.delete();
        else begin
            automatic bit room = q.size() < 2;
            if (q.size() > 0 && wb_ready) void'(q.pop_front());
            if (mem_valid && room) q.push_back('{waddr, wdata, we});
        end
    end

    // Monitor: whatever the DUTs present must be the oldest held beat (or a NOP)
    always @(negedge clk) begin
        automatic bit    v = q.size() > 0;
        automatic beat_t b = v ? q[0] : '0;
        automatic logic [1:0] ew;
        for (int k = 0; k < 2; k++) ew[k] = b.w[k] && b.a[k*5 +: 5] != 0;
        chk("u0 valid", {63'd0, vld0}, {63'd0, v});
        chk("u0 ready", {63'd0, rdy0}, {63'd0, q.size() < 2});
        chk("u0 occ", {62'd0, occ0}, 64'(q.size()));
        chk("u0 waddr", {54'd0, wa0}, {54'd0, b.a});
        chk("u0 wdata", wd0, b.d);
        chk("u0 we", {62'd0, we0}, {62'd0, ew});
        chk("u1 valid", {63'd0, vld1}, {63'd0, v});
        chk("u1 ready", {63'd0, rdy1}, {63'd0, q.size() < 2});
        chk("u1 occ", {62'd0, occ1}, 64'(q.size()));
        chk("u1 waddr", {59'd0, wa1}, {59'd0, b.a[4:0]});
        chk("u1 wdata", {32'd0, wd1}, {32'd0, b.d[31:0]});
        chk("u1 we", {63'd0, we1}, {63'd0, b.w[0]});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] a, input logic [63:0] d,
                         input logic [1:0] w, input logic r, input logic f);
        mem_valid = v; waddr = a; wdata = d; we = w; wb_ready = r; flush = f;
    endtask

    initial begin
        #2 rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        // stream three beats to r3 with WB always ready
        for (int i = 1; i <= 3; i++) begin
            drive(1, {5'd9, 5'd3}, {32'h100 + 32'(i), 32'(i)}, 2'b11, 1, 0);
            step();
        end
        drive(0, '0, '0, '0, 1, 0);
        step();
        // stall fill, then an offered beat that cannot enter until space frees
        drive(1, {5'd4, 5'd3}, {32'h0, 32'hA}, 2'b01, 0, 0); step();
        drive(1, {5'd4, 5'd3}, {32'h0, 32'hB}, 2'b01, 0, 0); step();
        chk("stall occ", {62'd0, occ0}, 64'd2);
        chk("stall hold", wd0, {32'h0, 32'hA});
        drive(1, {5'd4, 5'd3}, {32'h0, 32'hC}, 2'b01, 0, 0); step(); step();
        wb_ready = 1'b1; step(); step();
        drive(0, '0, '0, '0, 1, 0); step(); step();
        // flush from FULL with a simultaneous incoming beat
        drive(1, {5'd1, 5'd2}, {32'h0, 32'h5}, 2'b11, 0, 0); step();
        drive(1, {5'd1, 5'd2}, {32'h0, 32'h6}, 2'b11, 0, 0); step();
        drive(1, {5'd1, 5'd2}, {32'h0, 32'hD}, 2'b11, 0, 1); step();
        chk("flush valid", {63'd0, vld0}, 64'd0);
        chk("flush ready", {63'd0, rdy0}, 64'd1);
        drive(0, '0, '0, '0, 1, 0); step();
        // r0 suppression on u0 only, then independent lanes
        drive(1, {5'd0, 5'd0}, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 2'b11, 1, 0); step();
        chk("zs u0 we", {62'd0, we0}, 64'd0);
        chk("zs u1 we", {63'd0, we1}, 64'd1);
        drive(1, {5'd7, 5'd5}, {32'h22, 32'h11}, 2'b01, 1, 0); step();
        chk("lanes we", {62'd0, we0}, 64'd1);
        chk("lanes addr", {54'd0, wa0}, {54'd0, 5'd7, 5'd5});
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
                  {32'($urandom), 32'($urandom)}, 2'($urandom), 1'($urandom),
                  $urandom_range(0, 15) == 0);
            step();
        end
        // asynchronous reset while FULL, observed before the next clock edge
        drive(1, {5'd6, 5'd6}, {32'h1, 32'h1}, 2'b11, 0, 0); step(); step();
        drive(0, '0, '0, '0, 0, 0);
        chk("pre-rst occ", {62'd0, occ0}, 64'd2);
        #2 rst = 1'b0;
        #1;
        chk("async valid", {63'd0, vld0}, 64'd0);
        chk("async occ", {62'd0, occ0}, 64'd0);
        chk("async ready", {63'd0, rdy0}, 64'd1);
        step();
        rst = 1'b1;
        step(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
